dist_sensor_sched: RTL
======================

# dist_sensor_sched

Time-multiplexes the two ultrasonic range sensors over a single shared trigger/echo measurement engine, so they never ping at the same time and cannot hear each other's echoes. The block fires each sensor's trigger, times the echo pulse, converts the pulse width to whole centimetres and latches the result. Its `distance1_data` and `distance2_data` outputs drive the LED display block directly.

## Interface
- `TRIG_CYC`, default 500: trigger pulse width in clk cycles (10 µs at 50 MHz).
- `CM_CYC`, default 2900: echo-high clk cycles per centimetre (58 µs at 50 MHz).
- `ECHO_WAIT_CYC`, default 50000: maximum clk cycles from trigger end to echo rise.
- `MAX_CM`, default 400: range ceiling in cm; the measurement is aborted when it is reached.
- `GUARD_CYC`, default 3000000: quiet gap between consecutive pings, in clk cycles.
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low.
- `enable`, in, 1: run the ping schedule while high.
- `echo1`, in, 1: sensor 1 echo input; asynchronous.
- `echo2`, in, 1: sensor 2 echo input; asynchronous.
- `trig1`, out, 1: sensor 1 trigger; registered.
- `trig2`, out, 1: sensor 2 trigger; registered.
- `distance1_data`, out, 20: last sensor 1 result in cm.
- `distance2_data`, out, 20: last sensor 2 result in cm.
- `dist_valid`, out, 2: one-cycle strobe when a new result is written. Bit 0 is sensor 1, bit 1 is sensor 2.
- `timeout_err`, out, 2: sticky no-echo flag per sensor; cleared by the next good result from that sensor.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- Both echo inputs pass through a 2-FF synchronizer. Only the selected sensor's synchronized echo is examined.
- One shared 22-bit cycle counter serves every state. It is cleared on every state transition.
- A 20-bit cm counter accumulates the measured distance.
- A select bit `sel` chooses the active sensor: 0 selects sensor 1, 1 selects sensor 2.
- **IDLE**: if `enable` is high, go to TRIG on the next cycle.
- **TRIG**:
  - Drive `trig[sel]` high for exactly TRIG_CYC cycles, then go to WAIT_RISE.
  - Only one trig output may be high at any time.
- **WAIT_RISE**:
  - On synchronized echo high, clear the cm counter and go to MEASURE.
  - If the counter reaches ECHO_WAIT_CYC first, this is a timeout:
    - set `timeout_err[sel]`;
    - write 20'hFFFFF into `distance[sel]`;
    - pulse `dist_valid[sel]`;
    - go to GUARD.
- **MEASURE**:
  - Each time the cycle counter reaches CM_CYC-1, increment cm and wrap the cycle counter to 0.
  - On synchronized echo low:
    - write cm into `distance[sel]`; any partial centimetre is truncated;
    - clear `timeout_err[sel]`;
    - pulse `dist_valid[sel]`;
    - go to GUARD.
  - If cm reaches MAX_CM while the echo is still high, write MAX_CM and go to GUARD, treating it like a normal completion. `timeout_err` is not set.
- **GUARD**:
  - Count GUARD_CYC cycles, then toggle `sel`.
  - If `enable` is high, go to TRIG; otherwise go to IDLE.
- Dropping `enable` mid-ping does not abort the ping. The sequence finishes through GUARD and then returns to IDLE.
- Echo activity on the unselected sensor is ignored.

## Timing
- Reset values:
  - trig1 = trig2 = 0;
  - distance1_data = distance2_data = 0;
  - dist_valid = 0, timeout_err = 0, busy = 0;
  - state IDLE, sel = 0.
- Assertion of `reset` mid-operation takes effect immediately and asynchronously. All outputs return to their reset values and any trigger pulse is cut short.
- Trigger timing: `enable` sampled high in IDLE causes `trig1` to rise on the next clk edge.
- Echo latency: a raw echo edge is seen by the FSM 2 cycles later because of the synchronizer. The measurement therefore includes the same 2-cycle offset at both the start and the end of the pulse.
- Result timing: the distance register and the `dist_valid` strobe update on the same edge. The strobe is exactly one cycle wide.
- Ping period with a normal echo: 1 + TRIG_CYC + wait + echo + 1 + GUARD_CYC cycles.

## Configuration
- `DIST_TIMEOUT_HOLD_EN` defined:
  - a timeout leaves `distance[sel]` at its previous value;
  - `timeout_err[sel]` is still set;
  - `dist_valid[sel]` is not pulsed.
- `DIST_TIMEOUT_HOLD_EN` undefined: a timeout writes 20'hFFFFF and pulses `dist_valid`, as described in Operation.

## Test plan
All scenarios use TRIG_CYC=4, CM_CYC=10, ECHO_WAIT_CYC=50, MAX_CM=20, GUARD_CYC=8.
- **Basic ping, sensor 1**: enable=1; echo1 high for 73 cycles, starting 5 cycles after trig1 falls -> trig1 is high for 4 cycles; distance1_data=7; dist_valid=2'b01 for one cycle; trig2 stays 0 throughout.
- **Alternation**: echo1 high for 30 cycles, then echo2 high for 125 cycles -> distance1_data=3, then trig2 fires after the 8-cycle guard, then distance2_data=12; the triggers never overlap.
- **Timeout**: echo2 never rises.
  - Macro undefined -> after 50 wait cycles, distance2_data=20'hFFFFF, timeout_err[1]=1, one-cycle dist_valid[1] strobe.
  - Macro defined -> previous distance2_data is held and no strobe occurs.
  - In both cases, a following good 40-cycle echo clears timeout_err[1] and gives distance2_data=4.
- **Range ceiling**: echo1 held high for 500 cycles -> distance1_data=20, timeout_err[0]=0; the next sensor-2 ping proceeds normally.
- **Disable mid-ping**: drop enable during MEASURE -> the result is still written, busy falls after GUARD, no further trigger occurs, and sel has toggled to 1.
- **Reset mid-trigger**: assert reset while trig1=1 -> trig1=0 asynchronously and every output returns to its reset value; on release with enable=1, the schedule restarts from sensor 1.

Source files
------------

// File: rtl/dist_sensor_sched_if.sv
// rtl/dist_sensor_sched_if.sv - sensor trigger/echo, enable and result bundle of dist_sensor_sched
interface dist_sensor_sched_if;
    logic        enable;
    logic        echo1;
    logic        echo2;
    logic        trig1;
    logic        trig2;
    logic [19:0] distance1_data;
    logic [19:0] distance2_data;
    logic [1:0]  dist_valid;
    logic [1:0]  timeout_err;
    logic        busy;

    modport master (
        input  enable, echo1, echo2,
        output trig1, trig2, distance1_data, distance2_data, dist_valid, timeout_err, busy
    );

    modport slave (
        output enable, echo1, echo2,
        input  trig1, trig2, distance1_data, distance2_data, dist_valid, timeout_err, busy
    );
endinterface

// File: rtl/dist_sensor_sched.sv
// rtl/dist_sensor_sched.sv - two ultrasonic sensors sharing one trigger/echo engine, results in cm
// DIST_TIMEOUT_HOLD_EN: a timeout keeps the previous distance and gives no dist_valid strobe.
module dist_sensor_sched #(
    parameter int TRIG_CYC      = 500,
    parameter int CM_CYC        = 2900,
    parameter int ECHO_WAIT_CYC = 50000,
    parameter int MAX_CM        = 400,
    parameter int GUARD_CYC     = 3000000
) (
    input  logic                clk,
    input  logic                reset,
    dist_sensor_sched_if.master bus
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GUARD} state_t;

    localparam logic [21:0] TRIG_LAST  = 22'(TRIG_CYC - 1);
    localparam logic [21:0] WAIT_LAST  = 22'(ECHO_WAIT_CYC - 1);
    localparam logic [21:0] CM_LAST    = 22'(CM_CYC - 1);
    localparam logic [21:0] GUARD_LAST = 22'(GUARD_CYC - 1);
    localparam logic [19:0] CM_CEIL    = 20'(MAX_CM);

    state_t      state;
    logic        sel;
    logic [21:0] cnt;
    logic [19:0] cm;
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  trig;
    logic [1:0]  dist_valid;
    logic [1:0]  timeout_err;
    logic [19:0] dist1;
    logic [19:0] dist2;
    logic        busy;

    logic        echo;
    logic        cm_tick;
    logic [19:0] cm_next;

    assign echo    = sel ? sync2[1] : sync1[1];
    assign cm_tick = (cnt == CM_LAST);
    // The falling-edge cycle still counts, so a pulse of k*CM_CYC cycles reads exactly k cm.
    assign cm_next = cm + {19'd0, cm_tick};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sel         <= 1'b0;
            cnt         <= '0;
            cm          <= '0;
            sync1       <= '0;
            sync2       <= '0;
            trig        <= '0;
            dist_valid  <= '0;
            timeout_err <= '0;
            dist1       <= '0;
            dist2       <= '0;
            busy        <= 1'b0;
        end else begin
            sync1      <= {sync1[0], bus.echo1};
            sync2      <= {sync2[0], bus.echo2};
            dist_valid <= 2'b00;
            cnt        <= cnt + 22'd1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.enable) begin
                        state     <= TRIG;
                        trig[sel] <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        trig  <= 2'b00;
                        cnt   <= '0;
                        state <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (echo) begin
                        cm    <= '0;
                        cnt   <= '0;
                        state <= MEASURE;
                    end else if (cnt == WAIT_LAST) begin
                        timeout_err[sel] <= 1'b1;
`ifndef DIST_TIMEOUT_HOLD_EN
                        if (sel) dist2 <= 20'hFFFFF;
                        else     dist1 <= 20'hFFFFF;
                        dist_valid[sel] <= 1'b1;
`endif
                        cnt   <= '0;
                        state <= GUARD;
                    end
                end
                MEASURE: begin
                    if (!echo) begin
                        if (sel) dist2 <= cm_next;
                        else     dist1 <= cm_next;
                        timeout_err[sel] <= 1'b0;
                        dist_valid[sel]  <= 1'b1;
                        cnt              <= '0;
                        state            <= GUARD;
                    end else if (cm_tick) begin
                        cnt <= '0;
                        cm  <= cm_next;
                        if (cm_next == CM_CEIL) begin
                            if (sel) dist2 <= CM_CEIL;
                            else     dist1 <= CM_CEIL;
                            timeout_err[sel] <= 1'b0;
                            dist_valid[sel]  <= 1'b1;
                            state            <= GUARD;
                        end
                    end
                end
                GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        sel <= ~sel;
                        cnt <= '0;
                        if (bus.enable) begin
                            state      <= TRIG;
                            trig[~sel] <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    trig  <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trig1          = trig[0];
    assign bus.trig2          = trig[1];
    assign bus.distance1_data = dist1;
    assign bus.distance2_data = dist2;
    assign bus.dist_valid     = dist_valid;
    assign bus.timeout_err    = timeout_err;
    assign bus.busy           = busy;
endmodule
